// File: rtl/hwpe_cfg_arb_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_arb_pkg
// Shared types and constants for the HWPE configuration-port arbiter.
//   arb_state_e          : arbiter FSM state (IDLE, REQ, RESP)
//   HWPE_CFG_DATA_WIDTH  : data width of the HWPE configuration port
// -----------------------------------------------------------------------------
package hwpe_cfg_arb_pkg;

  localparam int unsigned HWPE_CFG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no transaction in flight
    REQ  = 2'd1,  // request presented to the HWPE, waiting for its grant
    RESP = 2'd2   // granted, waiting for the HWPE response
  } arb_state_e;

endpackage

// File: rtl/hwpe_cfg_rr_pick.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_rr_pick
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping from N-1 back to 0.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  search start index (always < N)
//   valid out 1      at least one request present
//   idx   out PTR_W  winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module hwpe_cfg_rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);

  // One extra bit so ptr + offset (at most 2N-2) cannot overflow before the
  // wrap subtraction.
  logic [PTR_W:0] cand;

  // NOTE: every signal written in always_comb gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk offsets from far to near so the nearest requester is written last
    // and therefore wins.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N)) begin
        cand = cand - (PTR_W+1)'(N);
      end
      if (req[cand[PTR_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hwpe_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_arbiter
// Shares the single HWPE configuration slave port among N_CORES cores with
// round-robin arbitration and exactly one transaction in flight. The winner's
// request is latched and presented to the HWPE; the response is routed back
// to the core that issued it.
//
// Optional feature (macro HWPE_CFG_ARB_PERF_EN):
//   adds perf_clr_i and stall_cnt_o, a saturating count of cycles in which
//   some core requests without being granted.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   slv_req_i .. slv_id_i    per-core request bundle (wen: 1 = read)
//   slv_gnt_o                per-core grant (one-hot or zero)
//   slv_r_valid_o            per-core response valid
//   slv_r_rdata_o/_id_o      response data/id, broadcast, zero when idle
//   mst_req_o .. mst_id_o    latched request toward the HWPE
//   mst_gnt_i                HWPE grant
//   mst_r_valid_i/_data_i/_id_i  HWPE response
//   busy_o                   transaction in flight
// -----------------------------------------------------------------------------
module hwpe_cfg_arbiter
  import hwpe_cfg_arb_pkg::*;
#(
  parameter int unsigned N_CORES    = 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [N_CORES-1:0]                            slv_req_i,
  input  logic [N_CORES-1:0][ADDR_WIDTH-1:0]            slv_add_i,
  input  logic [N_CORES-1:0]                            slv_wen_i,
  input  logic [N_CORES-1:0][3:0]                       slv_be_i,
  input  logic [N_CORES-1:0][HWPE_CFG_DATA_WIDTH-1:0]   slv_wdata_i,
  input  logic [N_CORES-1:0][ID_WIDTH-1:0]              slv_id_i,
  output logic [N_CORES-1:0]                            slv_gnt_o,
  output logic [N_CORES-1:0]                            slv_r_valid_o,
  output logic [HWPE_CFG_DATA_WIDTH-1:0]                slv_r_rdata_o,
  output logic [ID_WIDTH-1:0]                           slv_r_id_o,
  output logic                                          mst_req_o,
  output logic [ADDR_WIDTH-1:0]                         mst_add_o,
  output logic                                          mst_wen_o,
  output logic [3:0]                                    mst_be_o,
  output logic [HWPE_CFG_DATA_WIDTH-1:0]                mst_data_o,
  output logic [ID_WIDTH-1:0]                           mst_id_o,
  input  logic                                          mst_gnt_i,
  input  logic                                          mst_r_valid_i,
  input  logic [HWPE_CFG_DATA_WIDTH-1:0]                mst_r_data_i,
  input  logic [ID_WIDTH-1:0]                           mst_r_id_i,
`ifdef HWPE_CFG_ARB_PERF_EN
  input  logic                                          perf_clr_i,
  output logic [31:0]                                   stall_cnt_o,
`endif
  output logic                                          busy_o
);

  localparam int unsigned PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic             load;

  logic [ADDR_WIDTH-1:0]          add_q;
  logic                           wen_q;
  logic [3:0]                     be_q;
  logic [HWPE_CFG_DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]            id_q;

  // A single picker serves both arbitration points: ptr_q is already updated
  // at grant time, so the RESP-cycle re-arbitration sees the advanced pointer.
  hwpe_cfg_rr_pick #(
    .N     (N_CORES),
    .PTR_W (PTR_W)
  ) i_rr_pick (
    .req   (slv_req_i),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Next state, grant and response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    load          = 1'b0;
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    slv_r_rdata_o = '0;
    slv_r_id_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        if (mst_gnt_i) begin
          slv_gnt_o[owner_q] = 1'b1;
          ptr_d   = (owner_q == PTR_W'(N_CORES - 1)) ? '0 : owner_q + 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        if (mst_r_valid_i) begin
          slv_r_valid_o[owner_q] = 1'b1;
          slv_r_rdata_o          = mst_r_data_i;
          slv_r_id_o             = mst_r_id_i;
          // Back-to-back path: the next winner is latched in the response
          // cycle, giving one transaction every two cycles at best.
          if (pick_valid) begin
            load    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      owner_d = pick_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // State, pointer and owner registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched master request fields
  // ---------------------------------------------------------------------------
  // NOTE: these data registers are reset even though they are only meaningful
  // while mst_req_o is high, because they drive the mst_* outputs directly and
  // those must read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_q  <= '0;
      wen_q  <= 1'b0;
      be_q   <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else if (load) begin
      add_q  <= slv_add_i[pick_idx];
      wen_q  <= slv_wen_i[pick_idx];
      be_q   <= slv_be_i[pick_idx];
      data_q <= slv_wdata_i[pick_idx];
      id_q   <= slv_id_i[pick_idx];
    end
  end

  assign mst_req_o  = (state_q == REQ);
  assign mst_add_o  = add_q;
  assign mst_wen_o  = wen_q;
  assign mst_be_o   = be_q;
  assign mst_data_o = data_q;
  assign mst_id_o   = id_q;
  assign busy_o     = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef HWPE_CFG_ARB_PERF_EN
  logic stall;
  assign stall = |(slv_req_i & ~slv_gnt_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(slv_gnt_o));
  a_gnt_in_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_gnt_o != '0) |-> (state_q == REQ));
  a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(slv_r_valid_o));
`endif

endmodule

// File: tb/tb_hwpe_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hwpe_cfg_arbiter
// Self-checking bench for hwpe_cfg_arbiter (default parameters). Inputs are
// driven 1 ns after the rising edge and outputs sampled 1 ns later, well away
// from the next active edge.
// -----------------------------------------------------------------------------
module tb_hwpe_cfg_arbiter;

  localparam int N   = 8;
  localparam int IDW = 8;
  localparam int AW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]          slv_req;
  logic [N-1:0][AW-1:0]  slv_add;
  logic [N-1:0]          slv_wen;
  logic [N-1:0][3:0]     slv_be;
  logic [N-1:0][31:0]    slv_wdata;
  logic [N-1:0][IDW-1:0] slv_id;
  logic [N-1:0]          slv_gnt;
  logic [N-1:0]          slv_rv;
  logic [31:0]           slv_rdata;
  logic [IDW-1:0]        slv_rid;
  logic                  mst_req;
  logic [AW-1:0]         mst_add;
  logic                  mst_wen;
  logic [3:0]            mst_be;
  logic [31:0]           mst_data;
  logic [IDW-1:0]        mst_id;
  logic                  mst_gnt;
  logic                  mst_rv;
  logic [31:0]           mst_rdata;
  logic [IDW-1:0]        mst_rid;
  logic                  busy;
`ifdef HWPE_CFG_ARB_PERF_EN
  logic                  perf_clr;
  logic [31:0]           stall_cnt;
`endif

  hwpe_cfg_arbiter #(
    .N_CORES    (N),
    .ID_WIDTH   (IDW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slv_req_i     (slv_req),
    .slv_add_i     (slv_add),
    .slv_wen_i     (slv_wen),
    .slv_be_i      (slv_be),
    .slv_wdata_i   (slv_wdata),
    .slv_id_i      (slv_id),
    .slv_gnt_o     (slv_gnt),
    .slv_r_valid_o (slv_rv),
    .slv_r_rdata_o (slv_rdata),
    .slv_r_id_o    (slv_rid),
    .mst_req_o     (mst_req),
    .mst_add_o     (mst_add),
    .mst_wen_o     (mst_wen),
    .mst_be_o      (mst_be),
    .mst_data_o    (mst_data),
    .mst_id_o      (mst_id),
    .mst_gnt_i     (mst_gnt),
    .mst_r_valid_i (mst_rv),
    .mst_r_data_i  (mst_rdata),
    .mst_r_id_i    (mst_rid),
`ifdef HWPE_CFG_ARB_PERF_EN
    .perf_clr_i    (perf_clr),
    .stall_cnt_o   (stall_cnt),
`endif
    .busy_o        (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv_req   = '0;
    mst_gnt   = 1'b0;
    mst_rv    = 1'b0;
    mst_rdata = '0;
    mst_rid   = '0;
`ifdef HWPE_CFG_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference round-robin choice: first requester at or after ptr, wrapping.
  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic         rv;
    logic [31:0]  rdata;
    logic         exp_mreq;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    logic [31:0]  exp_rdata;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[6];

  // Random-phase model state
  int           m_ptr;
  int           m_owner;
  bit           m_resp;
  logic [AW-1:0]  m_add;
  logic           m_wen;
  logic [3:0]     m_be;
  logic [31:0]    m_data;
  logic [IDW-1:0] m_id;
  bit           pend [N];

  initial begin
    int last;
    int n_seen;
    int w;
    logic         exp_mreq;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;

    // Single-core read by core 3, then stray master inputs while idle.
    vecs[0] = '{8'h08, 1'b0, 1'b0, 32'h0,    1'b0, 8'h00, 8'h00, 32'h0,    1'b0};
    vecs[1] = '{8'h08, 1'b1, 1'b0, 32'h0,    1'b1, 8'h08, 8'h00, 32'h0,    1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 32'h0,    1'b0, 8'h00, 8'h00, 32'h0,    1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 32'hCAFE, 1'b0, 8'h00, 8'h08, 32'hCAFE, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 32'h1234, 1'b0, 8'h00, 8'h00, 32'h0,    1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 32'h0,    1'b0, 8'h00, 8'h00, 32'h0,    1'b0};

    slv_add   = '0;
    slv_wen   = '0;
    slv_be    = '0;
    slv_wdata = '0;
    slv_id    = '0;

    // ---- Reset values, with active-looking inputs applied during reset ----
    rst_n   = 1'b0;
    idle_inputs();
    slv_req = '1;
    mst_gnt = 1'b1;
    mst_rv  = 1'b1;
    mst_rdata = 32'hDEAD_BEEF;
    mst_rid   = 8'hEE;
    #3;
    check("rst.mst_req",   32'(mst_req),  32'h0);
    check("rst.mst_add",   mst_add,       32'h0);
    check("rst.mst_wen",   32'(mst_wen),  32'h0);
    check("rst.mst_be",    32'(mst_be),   32'h0);
    check("rst.mst_data",  mst_data,      32'h0);
    check("rst.mst_id",    32'(mst_id),   32'h0);
    check("rst.slv_gnt",   32'(slv_gnt),  32'h0);
    check("rst.slv_rv",    32'(slv_rv),   32'h0);
    check("rst.slv_rdata", slv_rdata,     32'h0);
    check("rst.slv_rid",   32'(slv_rid),  32'h0);
    check("rst.busy",      32'(busy),     32'h0);
    do_reset();

    // ---- Table: single core 3 read of 0x10 ----
    slv_add[3] = 32'h10;
    slv_wen[3] = 1'b1;
    slv_be[3]  = 4'hF;
    slv_id[3]  = 8'h33;
    for (int i = 0; i < 6; i++) begin
      slv_req   = vecs[i].req;
      mst_gnt   = vecs[i].gnt;
      mst_rv    = vecs[i].rv;
      mst_rdata = vecs[i].rdata;
      mst_rid   = 8'h5A;
      #1;
      check($sformatf("vec%0d.mst_req", i), 32'(mst_req), 32'(vecs[i].exp_mreq));
      check($sformatf("vec%0d.slv_gnt", i), 32'(slv_gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d.slv_rv", i),  32'(slv_rv),  32'(vecs[i].exp_rv));
      check($sformatf("vec%0d.rdata", i),   slv_rdata,    vecs[i].exp_rdata);
      check($sformatf("vec%0d.rid", i),     32'(slv_rid),
            (vecs[i].exp_rv != 0) ? 32'h5A : 32'h0);
      check($sformatf("vec%0d.busy", i),    32'(busy),    32'(vecs[i].exp_busy));
      if (vecs[i].exp_mreq) begin
        check($sformatf("vec%0d.mst_add", i), mst_add,       32'h10);
        check($sformatf("vec%0d.mst_wen", i), 32'(mst_wen),  32'h1);
        check($sformatf("vec%0d.mst_id", i),  32'(mst_id),   32'h33);
      end
      tick();
    end

    // ---- All cores contend, immediate grant, 1-cycle response ----
    do_reset();
    for (int i = 0; i < N; i++) slv_add[i] = 32'h100 + 32'(i);
    slv_req = '1;
    mst_gnt = 1'b1;
    mst_rv  = 1'b1;
    last    = 0;
    n_seen  = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (slv_gnt != '0) begin
        check("rr.order",   32'(slv_gnt), 32'(8'h01 << (n_seen % N)));
        check("rr.add",     mst_add,      32'h100 + 32'(n_seen % N));
        if (n_seen > 0) check("rr.period", 32'(cyc - last), 32'd2);
        last = cyc;
        n_seen++;
      end
      tick();
    end
    check("rr.count", 32'(n_seen), 32'd10);

    // ---- Master backpressure ----
    do_reset();
    slv_add[2]   = 32'hA0A0_0002;
    slv_wdata[2] = 32'hD0D0_0002;
    slv_add[6]   = 32'hA0A0_0006;
    slv_req      = 8'h44;
    #1;
    check("bp.idle_busy", 32'(busy), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.mst_req",  32'(mst_req), 32'h1);
      check("bp.mst_add",  mst_add,      32'hA0A0_0002);
      check("bp.mst_data", mst_data,     32'hD0D0_0002);
      check("bp.no_gnt",   32'(slv_gnt), 32'h0);
      tick();
    end
    mst_gnt = 1'b1;
    #1;
    check("bp.gnt2", 32'(slv_gnt), 32'h04);
    tick();
    slv_req   = 8'h40;
    mst_gnt   = 1'b0;
    mst_rv    = 1'b1;
    mst_rdata = 32'h77;
    #1;
    check("bp.rv2",    32'(slv_rv), 32'h04);
    check("bp.rdata2", slv_rdata,   32'h77);
    tick();
    mst_rv  = 1'b0;
    mst_gnt = 1'b1;
    #1;
    check("bp.add6", mst_add,      32'hA0A0_0006);
    check("bp.gnt6", 32'(slv_gnt), 32'h40);
    tick();
    idle_inputs();

    // ---- Back-to-back owner: core 0 re-requests while core 5 waits ----
    do_reset();
    slv_add[0] = 32'hB0;
    slv_add[5] = 32'hB5;
    slv_req    = 8'h01;
    tick();
    mst_gnt = 1'b1;
    #1;
    check("b2b.gnt0", 32'(slv_gnt), 32'h01);
    tick();
    mst_gnt = 1'b0;
    mst_rv  = 1'b1;
    slv_req = 8'h21;
    #1;
    check("b2b.rv0", 32'(slv_rv), 32'h01);
    tick();
    mst_rv  = 1'b0;
    mst_gnt = 1'b1;
    #1;
    check("b2b.add5", mst_add,      32'hB5);
    check("b2b.gnt5", 32'(slv_gnt), 32'h20);
    tick();
    mst_gnt = 1'b0;
    mst_rv  = 1'b1;
    slv_req = 8'h01;
    #1;
    check("b2b.rv5", 32'(slv_rv), 32'h20);
    tick();
    mst_rv  = 1'b0;
    mst_gnt = 1'b1;
    #1;
    check("b2b.add0", mst_add,      32'hB0);
    check("b2b.gnt0b", 32'(slv_gnt), 32'h01);
    tick();
    idle_inputs();

    // ---- Reset while waiting for a response ----
    do_reset();
    slv_req = 8'h02;
    tick();
    mst_gnt = 1'b1;
    tick();
    slv_req = '0;
    mst_gnt = 1'b0;
    #1;
    check("rr_resp.busy_before", 32'(busy), 32'h1);
    rst_n  = 1'b0;
    mst_rv = 1'b1;
    #1;
    check("rr_resp.busy_in_rst", 32'(busy),    32'h0);
    check("rr_resp.rv_in_rst",   32'(slv_rv),  32'h0);
    check("rr_resp.req_in_rst",  32'(mst_req), 32'h0);
    tick();
    rst_n   = 1'b1;
    slv_req = 8'h81;
    #1;
    check("rr_resp.rv_after", 32'(slv_rv), 32'h0);
    check("rr_resp.busy_after", 32'(busy), 32'h0);
    tick();
    mst_rv  = 1'b0;
    mst_gnt = 1'b1;
    #1;
    check("rr_resp.ptr0_gnt", 32'(slv_gnt), 32'h01);
    tick();
    idle_inputs();

`ifdef HWPE_CFG_ARB_PERF_EN
    // ---- Stall counter: cores 1 and 2 contend, master waits 3 cycles ----
    do_reset();
    slv_req = 8'h06;
    repeat (4) tick();
    mst_gnt = 1'b1;
    tick();
    slv_req  = 8'h04;
    mst_gnt  = 1'b0;
    perf_clr = 1'b1;
    #1;
    check("perf.cnt5", stall_cnt, 32'd5);
    tick();
    perf_clr = 1'b0;
    #1;
    check("perf.clr", stall_cnt, 32'd0);
    tick();
    idle_inputs();
`endif

    // ---- Randomized traffic against a transaction-level model ----
    do_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_resp  = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i]      = 1'b1;
          slv_add[i]   = $urandom;
          slv_wen[i]   = 1'($urandom);
          slv_be[i]    = 4'($urandom);
          slv_wdata[i] = $urandom;
          slv_id[i]    = IDW'($urandom);
        end
        slv_req[i] = pend[i];
      end
      mst_gnt   = 1'($urandom_range(0, 1));
      mst_rv    = ($urandom_range(0, 2) == 0);
      mst_rdata = $urandom;
      mst_rid   = IDW'($urandom);
      #1;
      exp_mreq = (m_owner >= 0) && !m_resp;
      exp_gnt  = (exp_mreq && mst_gnt) ? (8'h01 << m_owner) : 8'h00;
      exp_rv   = (m_resp && mst_rv)    ? (8'h01 << m_owner) : 8'h00;
      check("rnd.mst_req", 32'(mst_req),   32'(exp_mreq));
      check("rnd.slv_gnt", 32'(slv_gnt),   32'(exp_gnt));
      check("rnd.slv_rv",  32'(slv_rv),    32'(exp_rv));
      check("rnd.rdata",   slv_rdata,      (exp_rv != 0) ? mst_rdata : 32'h0);
      check("rnd.rid",     32'(slv_rid),   (exp_rv != 0) ? 32'(mst_rid) : 32'h0);
      check("rnd.busy",    32'(busy),      32'(m_owner >= 0));
      if (exp_mreq) begin
        check("rnd.mst_add",  mst_add,       m_add);
        check("rnd.mst_wen",  32'(mst_wen),  32'(m_wen));
        check("rnd.mst_be",   32'(mst_be),   32'(m_be));
        check("rnd.mst_data", mst_data,      m_data);
        check("rnd.mst_id",   32'(mst_id),   32'(m_id));
      end
      if (exp_gnt != 0) begin
        pend[m_owner] = 1'b0;
        m_ptr  = (m_owner + 1) % N;
        m_resp = 1'b1;
      end else if ((m_resp && mst_rv) || (m_owner < 0)) begin
        w       = rr_winner(slv_req, m_ptr);
        m_resp  = 1'b0;
        m_owner = w;
        if (w >= 0) begin
          m_add  = slv_add[w];
          m_wen  = slv_wen[w];
          m_be   = slv_be[w];
          m_data = slv_wdata[w];
          m_id   = slv_id[w];
        end
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
